// File: rtl/count_sched_pkg.sv
// count_sched_pkg: FSM states, counter range constants and helpers shared by the scheduler and its bench.
// exp_result models the 2..10 wrapping counter: ((din-2 +/- steps) mod 9) + 2.
package count_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    CAPT = 2'd3
  } state_t;

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MIN = 4'd2;
  localparam logic [CNT_W-1:0] CNT_MAX = 4'd10;
  localparam int CNT_SPAN = 9;

  function automatic logic [CNT_W-1:0] clamp_din(input logic [CNT_W-1:0] din);
    if (din < CNT_MIN) begin
      return CNT_MIN;
    end else if (din > CNT_MAX) begin
      return CNT_MAX;
    end
    return din;
  endfunction

  function automatic logic [CNT_W-1:0] exp_result(input logic [CNT_W-1:0] din,
                                                 input logic             up,
                                                 input logic [CNT_W-1:0] steps);
    int v;
    v = int'(din) - int'(CNT_MIN) + (up ? int'(steps) : -int'(steps));
    v = v % CNT_SPAN;
    if (v < 0) begin
      v = v + CNT_SPAN;
    end
    return CNT_W'(v + int'(CNT_MIN));
  endfunction

endpackage

// File: rtl/count_sched_if.sv
// count_sched_if: job request side plus counter pin side of the scheduler.
// master = requesters and counter environment, slave = the scheduler.
interface count_sched_if #(parameter int NREQ = 2);

  logic [NREQ-1:0]   req;
  logic [4*NREQ-1:0] req_din;
  logic [NREQ-1:0]   req_up;
  logic [4*NREQ-1:0] req_steps;
  logic [NREQ-1:0]   grant;
  logic              busy;
  logic              done;
  logic [3:0]        result;
  logic [3:0]        cnt_din;
  logic              cnt_load;
  logic              cnt_up_down;
  logic [3:0]        cnt_count;

  modport master (
    output req, req_din, req_up, req_steps, cnt_count,
    input  grant, busy, done, result, cnt_din, cnt_load, cnt_up_down
  );

  modport slave (
    input  req, req_din, req_up, req_steps, cnt_count,
    output grant, busy, done, result, cnt_din, cnt_load, cnt_up_down
  );

endinterface

// File: rtl/count_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick over NREQ level requests.
// The search starts one past the last winner; the pointer only moves when i_adv accepts a grant.
module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic [NREQ-1:0]         i_req,
  input  logic                    i_adv,
  output logic [NREQ-1:0]         o_gnt,
  output logic [$clog2(NREQ)-1:0] o_idx
);

  localparam int IW = $clog2(NREQ);

  logic [IW-1:0]   r_ptr;
  logic [IW-1:0]   w_idx;
  logic            w_found;
  logic [NREQ-1:0] w_gnt;

  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int ofs);
    int s;
    s = int'(base) + ofs;
    if (s >= NREQ) begin
      s = s - NREQ;
    end
    return IW'(s);
  endfunction

  // Scan from farthest to nearest offset so the closest requester after r_ptr wins.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (i_req[wrap_add(r_ptr, k)]) begin
        w_found = 1'b1;
        w_idx   = wrap_add(r_ptr, k);
      end
    end
  end

  always_comb begin
    w_gnt = '0;
    if (w_found) begin
      w_gnt[w_idx] = 1'b1;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_ptr <= '0;
    end else if (i_adv && w_found) begin
      r_ptr <= wrap_add(w_idx, 1);
    end
  end

  assign o_gnt = w_gnt;
  assign o_idx = w_idx;

endmodule

// File: rtl/count_sched.sv
// count_sched: round-robin scheduler sharing one 2..10 up/down counter among NREQ requesters.
// Define COUNT_SCHED_CLAMP_EN to clamp accepted start values into 2..10.
module count_sched
  import count_sched_pkg::*;
#(
  parameter int NREQ = 2
) (
  input logic          i_clock,
  input logic          i_reset,
  count_sched_if.slave bus
);

  localparam int IW = $clog2(NREQ);

  state_t r_state;
  state_t w_next;

  logic [NREQ-1:0]  w_gnt;
  logic [IW-1:0]    w_idx;
  logic             w_any;
  logic             w_idle;
  logic             w_accept;
  logic [CNT_W-1:0] w_win_din;
  logic [CNT_W-1:0] w_win_steps;
  logic             w_win_up;
  logic [CNT_W-1:0] w_lat_din;
  logic             w_busy;
  logic             w_cnt_load;

  logic [NREQ-1:0]  r_grant;
  logic             r_done;
  logic [CNT_W-1:0] r_result;
  logic [CNT_W-1:0] r_cnt_din;
  logic             r_cnt_up_down;
  logic [CNT_W-1:0] r_steps_left;

  assign w_idle   = (r_state == IDLE);
  assign w_any    = |w_gnt;
  assign w_accept = w_idle && w_any;

  rr_arbiter #(
    .NREQ(NREQ)
  ) u_arb (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_req   (bus.req),
    .i_adv   (w_idle),
    .o_gnt   (w_gnt),
    .o_idx   (w_idx)
  );

  assign w_win_din   = bus.req_din[CNT_W*w_idx +: CNT_W];
  assign w_win_steps = bus.req_steps[CNT_W*w_idx +: CNT_W];
  assign w_win_up    = bus.req_up[w_idx];

`ifdef COUNT_SCHED_CLAMP_EN
  assign w_lat_din = clamp_din(w_win_din);
`else
  assign w_lat_din = w_win_din;
`endif

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // r_steps_left == 1 in RUN means this is the last count edge.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_any ? LOAD : IDLE;
      LOAD:    w_next = (r_steps_left != '0) ? RUN : CAPT;
      RUN:     w_next = (r_steps_left == 4'd1) ? CAPT : RUN;
      CAPT:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_busy     = 1'b1;
    w_cnt_load = 1'b1;
    case (r_state)
      IDLE:    w_busy     = 1'b0;
      LOAD:    w_cnt_load = 1'b0;
      default: ;
    endcase
  end

  // Direction is latched at acceptance; the active-low load overrides it during LOAD.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_grant       <= '0;
      r_done        <= 1'b0;
      r_result      <= '0;
      r_cnt_din     <= '0;
      r_cnt_up_down <= 1'b1;
      r_steps_left  <= '0;
    end else begin
      r_grant <= w_accept ? w_gnt : '0;
      r_done  <= (r_state == CAPT);
      if (w_accept) begin
        r_cnt_din     <= w_lat_din;
        r_cnt_up_down <= w_win_up;
        r_steps_left  <= w_win_steps;
      end else if (r_state == RUN) begin
        r_steps_left  <= r_steps_left - 4'd1;
      end
      if (r_state == CAPT) begin
        r_result <= bus.cnt_count;
      end
    end
  end

  assign bus.grant       = r_grant;
  assign bus.busy        = w_busy;
  assign bus.done        = r_done;
  assign bus.result      = r_result;
  assign bus.cnt_din     = r_cnt_din;
  assign bus.cnt_load    = w_cnt_load;
  assign bus.cnt_up_down = r_cnt_up_down;

endmodule

// File: tb/tb_count_sched.sv
// Bench for count_sched: behavioural 2..10 counter, table-driven jobs, fairness and mid-run reset sequences.
module tb_count_sched;
  import count_sched_pkg::*;

  localparam int NREQ = 2;

  typedef struct {
    int         r;
    logic [3:0] din;
    logic       up;
    logic [3:0] steps;
    logic [3:0] exp_res;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  count_sched_if #(.NREQ(NREQ)) bus ();

  count_sched #(.NREQ(NREQ)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  // External counter: active-low sync load, wraps 10->2 going up and 2->10 going down.
  logic [3:0] cnt_q = 4'd2;
  always @(posedge clk) begin
    if (!bus.cnt_load) begin
      cnt_q <= bus.cnt_din;
    end else if (bus.cnt_up_down) begin
      cnt_q <= (cnt_q >= 4'd10) ? 4'd2 : cnt_q + 4'd1;
    end else begin
      cnt_q <= (cnt_q <= 4'd2) ? 4'd10 : cnt_q - 4'd1;
    end
  end
  assign bus.cnt_count = cnt_q;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input int act, input int exp_v);
    n_tests++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input int r, input logic [3:0] din, input logic up,
                         input logic [3:0] steps, input logic [3:0] exp_res);
    int lat;
    logic [3:0] exp_din;
`ifdef COUNT_SCHED_CLAMP_EN
    exp_din = (din < 4'd2) ? 4'd2 : ((din > 4'd10) ? 4'd10 : din);
`else
    exp_din = din;
`endif
    bus.req_din[4*r +: 4]   = din;
    bus.req_steps[4*r +: 4] = steps;
    bus.req_up[r]           = up;
    bus.req[r]              = 1'b1;
    tick();
    chk("grant", int'(bus.grant), 1 << r);
    chk("load_busy", int'(bus.busy), 1);
    chk("load_cnt_load", int'(bus.cnt_load), 0);
    chk("load_cnt_din", int'(bus.cnt_din), int'(exp_din));
    bus.req[r] = 1'b0;
    lat = 0;
    while (!bus.done && lat < 40) begin
      tick();
      lat++;
      if (lat == 1 && steps != 4'd0) begin
        chk("run_dir", int'(bus.cnt_up_down), int'(up));
      end
    end
    chk("done_latency", lat, int'(steps) + 2);
    chk("result", int'(bus.result), int'(exp_res));
    chk("done_busy", int'(bus.busy), 0);
  endtask

  vec_t vecs[9];
  int   order[4];
  int   n_gnt;
  int   cyc;
  int   n_done;
  logic prev_busy;

  initial begin
    #500000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{r: 0, din: 4'd3,  up: 1'b1, steps: 4'd4,  exp_res: 4'd7};
    vecs[1] = '{r: 1, din: 4'd9,  up: 1'b1, steps: 4'd3,  exp_res: 4'd3};
    vecs[2] = '{r: 0, din: 4'd3,  up: 1'b0, steps: 4'd4,  exp_res: 4'd8};
    vecs[3] = '{r: 1, din: 4'd6,  up: 1'b1, steps: 4'd0,  exp_res: 4'd6};
    vecs[4] = '{r: 0, din: 4'd2,  up: 1'b0, steps: 4'd1,  exp_res: 4'd10};
    vecs[5] = '{r: 1, din: 4'd10, up: 1'b1, steps: 4'd1,  exp_res: 4'd2};
    vecs[6] = '{r: 0, din: 4'd7,  up: 1'b0, steps: 4'd15, exp_res: 4'd10};
    vecs[7] = '{r: 1, din: 4'd4,  up: 1'b1, steps: 4'd15, exp_res: 4'd10};
`ifdef COUNT_SCHED_CLAMP_EN
    vecs[8] = '{r: 0, din: 4'd14, up: 1'b1, steps: 4'd1,  exp_res: 4'd2};
`else
    vecs[8] = '{r: 0, din: 4'd5,  up: 1'b1, steps: 4'd1,  exp_res: 4'd6};
`endif

    bus.req       = '0;
    bus.req_din   = '0;
    bus.req_up    = '0;
    bus.req_steps = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_grant", int'(bus.grant), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_result", int'(bus.result), 0);
    chk("rst_cnt_din", int'(bus.cnt_din), 0);
    chk("rst_cnt_load", int'(bus.cnt_load), 1);
    chk("rst_cnt_up_down", int'(bus.cnt_up_down), 1);

    for (int i = 0; i < 9; i++) begin
      run_job(vecs[i].r, vecs[i].din, vecs[i].up, vecs[i].steps, vecs[i].exp_res);
    end

    // Fairness: both requesters held; pointer restarts at requester 0 after reset.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req_din   = {4'd2, 4'd2};
    bus.req_steps = {4'd1, 4'd1};
    bus.req_up    = 2'b11;
    bus.req       = 2'b11;
    prev_busy = bus.busy;
    n_gnt = 0;
    cyc = 0;
    while (n_gnt < 4 && cyc < 100) begin
      tick();
      cyc++;
      if (bus.grant != '0) begin
        chk("grant_while_busy", int'(prev_busy), 0);
        order[n_gnt] = (bus.grant == 2'b01) ? 0 : ((bus.grant == 2'b10) ? 1 : 9);
        n_gnt++;
      end
      if (bus.done) begin
        chk("fair_result", int'(bus.result), int'(exp_result(4'd2, 1'b1, 4'd1)));
      end
      prev_busy = bus.busy;
    end
    bus.req = '0;
    chk("fair_grants", n_gnt, 4);
    chk("fair_order0", order[0], 0);
    chk("fair_order1", order[1], 1);
    chk("fair_order2", order[2], 0);
    chk("fair_order3", order[3], 1);
    cyc = 0;
    while (!bus.done && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("fair_drain_done", int'(bus.done), 1);

    // Zero-step job, then a reset pulse in the middle of a long RUN.
    run_job(0, 4'd6, 1'b1, 4'd0, 4'd6);
    bus.req_din[7:4]   = 4'd3;
    bus.req_steps[7:4] = 4'd8;
    bus.req_up[1]      = 1'b1;
    bus.req[1]         = 1'b1;
    tick();
    chk("mid_grant", int'(bus.grant), 2);
    bus.req[1] = 1'b0;
    tick();
    tick();
    tick();
    chk("mid_busy_before", int'(bus.busy), 1);
    rst = 1'b1;
    tick();
    chk("mid_rst_busy", int'(bus.busy), 0);
    chk("mid_rst_cnt_load", int'(bus.cnt_load), 1);
    chk("mid_rst_done", int'(bus.done), 0);
    chk("mid_rst_result", int'(bus.result), 0);
    chk("mid_rst_grant", int'(bus.grant), 0);
    rst = 1'b0;
    n_done = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bus.done) begin
        n_done++;
      end
    end
    chk("mid_rst_no_done", n_done, 0);
    chk("mid_rst_idle", int'(bus.busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
